dvsd_adder_12bit: RTL and testbench
===================================

DVSD_ADDER_12BIT -- requirements
Module: dvsd_adder_12bit

Interface
REQ-001 Parameter WIDTH, default 12: operand/sum width; SHALL be a multiple of CLA_W.
REQ-002 Parameter CLA_W, default 4: width of one carry-lookahead slice.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 CE  input  1  clock enable; 1 = capture new result on this edge.
REQ-007 A  input  WIDTH  unsigned operand A.
REQ-008 B  input  WIDTH  unsigned operand B.
REQ-009 Cin  input  1  carry-in, weight 1.
REQ-010 S  output  WIDTH  registered sum, A+B+Cin mod 2^WIDTH.
REQ-011 Cout  output  1  registered carry-out of bit WIDTH-1.

Function
REQ-012 Combinational core SHALL compute {Cout_n, S_n} = A + B + Cin as an unsigned (WIDTH+1)-bit result.
REQ-013 Core SHALL be WIDTH/CLA_W ripple-chained 4-bit CLA slices: carry-in of slice 0 is Cin, carry-in of slice k is carry-out of slice k-1, Cout_n is carry-out of the last slice.
REQ-014 Each slice SHALL form per-bit generate g=a&b and propagate p=a^b, and compute all internal carries c1..c4 by lookahead equations from g, p and slice carry-in; no bit-to-bit ripple inside a slice.
REQ-015 Slice sum bits SHALL be p xor incoming bit carry.
REQ-016 On a rising clk edge with CE=1 and rst=0, S and Cout SHALL load S_n and Cout_n; latency is exactly 1 clock from inputs to outputs.
REQ-017 On a rising clk edge with CE=0, S and Cout SHALL hold their previous values regardless of A, B, Cin.
REQ-018 Overflow SHALL wrap: S = low WIDTH bits, Cout = 1 exactly when A+B+Cin >= 2^WIDTH.
REQ-019 Outputs SHALL change only on a clk edge or on reset assertion; no combinational path from inputs to S/Cout.

Reset
REQ-020 rst=1 SHALL immediately (asynchronously) force S=0 and Cout=0, independent of clk and CE.
REQ-021 While rst=1, outputs SHALL remain 0; after deassertion, the first rising edge with CE=1 SHALL load the current sum.
REQ-022 Reset asserted mid-operation SHALL discard the held result; no state survives reset.

Structure
REQ-023 WIDTH and CLA_W defaults SHALL live in a shared package dvsd_adder_pkg, together with the slice count constant.
REQ-024 One sub-module dvsd_cla_4bit (ports a[3:0], b[3:0], cin, s[3:0], cout; purely combinational) SHALL be instantiated WIDTH/CLA_W times via generate.
REQ-025 Top level SHALL contain only the slice chain and the output register (WIDTH+1 flops with enable and async reset).

Verification
REQ-026 rst=1 then released, CE=0, A=4, B=2, Cin=1 for several edges -> S=0, Cout=0 held.
REQ-027 CE=1: A=4, B=2, Cin=1 -> after one edge S=7, Cout=0; A=999, B=2550, Cin=1 -> S=3550, Cout=0; A=9, B=9, Cin=0 -> S=18, Cout=0.
REQ-028 Overflow: A=3438, B=696, Cin=1 (12-bit truncations of 122222/8888) -> S=39, Cout=1; A=4095, B=0, Cin=1 -> S=0, Cout=1.
REQ-029 Hold: load A=2, B=9, Cin=0 (S=11), then CE=0 and A=B=4095, Cin=1 -> S stays 11, Cout stays 0.
REQ-030 Async reset between edges while S=3550 -> S=0, Cout=0 before next clk edge; cross-slice carry A=15, B=1, Cin=0 -> S=16, and A=255, B=1 -> S=256.
REQ-031 Random: 10,000 random A, B, Cin with random CE -> registered S/Cout match (A+B+Cin) captured at last CE=1 edge.

Source files
------------

// File: rtl/dvsd_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dvsd_adder_pkg
// Purpose  : Shared sizing constants and types for the registered CLA adder.
// Revision : 1.0 - initial release
// ============================================================================
package dvsd_adder_pkg;

    localparam int c_WIDTH = 12;
    localparam int c_CLA_W = 4;
    localparam int c_NUM_SLICES = c_WIDTH / c_CLA_W;

    typedef logic [3:0] nibble_t;

    function automatic int slice_count(input int width, input int cla_w);
        return width / cla_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dvsd_cla_4bit.sv
`default_nettype none
// ============================================================================
// Module   : dvsd_cla_4bit
// Purpose  : Purely combinational 4-bit carry-lookahead adder slice.
// Revision : 1.0 - initial release
// ============================================================================
module dvsd_cla_4bit
    import dvsd_adder_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    nibble_t w_g;
    nibble_t w_p;
    nibble_t w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Every carry is a flat sum of products of g, p and cin.
    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);
    assign cout   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

    assign s = w_p ^ w_c;

endmodule
`default_nettype wire

// File: rtl/dvsd_adder_12bit.sv
`default_nettype none
// ============================================================================
// Module   : dvsd_adder_12bit
// Purpose  : Chain of CLA slices feeding an enabled, async-reset result register.
// Revision : 1.0 - initial release
// ============================================================================
module dvsd_adder_12bit
    import dvsd_adder_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int CLA_W = c_CLA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             CE,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int NSLICE = slice_count(WIDTH, CLA_W);

    logic [NSLICE:0]  w_carry;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    assign w_carry[0] = Cin;

    // Slices ripple only at slice boundaries.
    for (genvar k = 0; k < NSLICE; k++) begin : g_slice
        dvsd_cla_4bit u_cla (
            .a    (A[k*CLA_W +: CLA_W]),
            .b    (B[k*CLA_W +: CLA_W]),
            .cin  (w_carry[k]),
            .s    (w_sum[k*CLA_W +: CLA_W]),
            .cout (w_carry[k+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (CE) begin
            r_sum  <= w_sum;
            r_cout <= w_carry[NSLICE];
        end
    end

    assign S    = r_sum;
    assign Cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_dvsd_adder_12bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_dvsd_adder_12bit
// Purpose  : Self-checking bench for the registered 12-bit CLA adder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dvsd_adder_12bit;

    localparam int W = 12;

    logic         clk;
    logic         rst;
    logic         CE;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic [W-1:0] S;
    logic         Cout;

    int n_checks;
    int n_fail;

    // Reference: the sum captured at the most recent enabled edge.
    int model_s;
    int model_c;

    dvsd_adder_12bit u_dut (
        .clk  (clk),
        .rst  (rst),
        .CE   (CE),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .S    (S),
        .Cout (Cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, required %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        int sum;
        @(posedge clk);
        if (CE && !rst) begin
            sum     = int'(A) + int'(B) + int'(Cin);
            model_s = sum % (1 << W);
            model_c = (sum >= (1 << W)) ? 1 : 0;
        end
        #1;
    endtask

    task automatic load(input int a, input int b, input int cin, input int es, input int ec);
        A   = W'(a);
        B   = W'(b);
        Cin = cin[0];
        CE  = 1'b1;
        tick();
        check("load_s", int'(S), es);
        check("load_cout", int'(Cout), ec);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_s  = 0;
        model_c  = 0;
        rst = 1'b1;
        CE  = 1'b0;
        A   = W'(4);
        B   = W'(2);
        Cin = 1'b1;
        #2;
        check("reset_s", int'(S), 0);
        check("reset_cout", int'(Cout), 0);

        // Release reset between edges, then hold with CE low.
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ce0_s", int'(S), 0);
            check("ce0_cout", int'(Cout), 0);
        end

        load(4, 2, 1, 7, 0);
        load(999, 2550, 1, 3550, 0);
        load(9, 9, 0, 18, 0);
        load(3438, 696, 1, 39, 1);
        load(4095, 0, 1, 0, 1);
        load(2, 9, 0, 11, 0);

        CE  = 1'b0;
        A   = '1;
        B   = '1;
        Cin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_s", int'(S), 11);
            check("hold_cout", int'(Cout), 0);
        end

        // Asynchronous reset between edges must clear immediately.
        load(999, 2550, 1, 3550, 0);
        CE  = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_s", int'(S), 0);
        check("async_rst_cout", int'(Cout), 0);
        #1;
        rst = 1'b0;
        model_s = 0;
        model_c = 0;

        load(15, 1, 0, 16, 0);
        load(255, 1, 0, 256, 0);
        load(4095, 4095, 1, 4095, 1);
        load(2048, 2048, 0, 0, 1);

        for (int i = 0; i < 10000; i++) begin
            A   = W'($urandom);
            B   = W'($urandom);
            Cin = 1'($urandom);
            CE  = ($urandom_range(0, 3) != 0);
            tick();
            check("rand_s", int'(S), model_s);
            check("rand_cout", int'(Cout), model_c);
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                #1;
                model_s = 0;
                model_c = 0;
                check("rand_rst_s", int'(S), model_s);
                check("rand_rst_cout", int'(Cout), model_c);
                rst = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
